aq_ifu_ibuf_ctrl: RTL
=====================

# aq_ifu_ibuf_ctrl

Pointer and occupancy controller for the IFU instruction buffer. It sits between the IFU fetch pipeline and the array of instruction buffer entries. It accepts one or two instructions per cycle from fetch and drives per-entry one-hot create, data-select and retire enables. It presents the head entry to IDU with a valid/ready handshake and handles flush.

## Interface
Parameters:
- ENTRY_NUM, 8, number of buffer entries; power of two, 4..16
- PTR_W, 3, pointer width; must equal log2(ENTRY_NUM)

Ports:
- forever_cpuclk  in  1  clock
- cpurst_b  in  1  reset, asynchronous, active-low
- ibuf_flush_en  in  1  flush; empties the buffer
- ifu_ibuf_create_vld  in  1  fetch offers instructions this cycle
- ifu_ibuf_create_num  in  2  instructions offered, 1 or 2; values 0 and 3 are illegal while vld
- ibuf_ifu_create_rdy  out  1  buffer can take 2 instructions (free >= 2)
- ibuf_entry_create_en  out  ENTRY_NUM  one-hot-or-two-hot write enable per entry
- ibuf_entry_create_sel  out  ENTRY_NUM  per entry: 1 = write slot-1 data, 0 = slot-0 data
- ibuf_idu_inst_vld  out  1  head instruction valid to IDU
- idu_ibuf_retire_rdy  in  1  IDU accepts head
- ibuf_entry_retire_en  out  ENTRY_NUM  one-hot retire of head entry
- ibuf_rd_ptr  out  PTR_W  head entry index (IDU read mux select)
- ibuf_entry_cnt  out  PTR_W+1  occupied entries
- ibuf_empty  out  1  cnt == 0
- ibuf_full  out  1  cnt == ENTRY_NUM
- ibuf_idu_bypass_sel  out  1  IDU takes slot-0 fetch data directly (see Configuration)

## Operation
- State: wr_ptr, rd_ptr (PTR_W bits, wrap modulo ENTRY_NUM), cnt (PTR_W+1 bits). All reset to 0.
- create_acc = ifu_ibuf_create_vld & ibuf_ifu_create_rdy & !ibuf_flush_en.
- ibuf_ifu_create_rdy = (ENTRY_NUM - cnt) >= 2, computed from registered cnt only. It does not depend on a same-cycle retire.
- On create_acc:
  - Slot 0 goes to entry wr_ptr with sel=0.
  - If num==2, slot 1 goes to entry wr_ptr+1 (wrapped) with sel=1.
  - wr_ptr advances by num.
- retire_acc = ibuf_idu_inst_vld & idu_ibuf_retire_rdy & !ibuf_flush_en & !bypass. When set, retire_en[rd_ptr]=1 and rd_ptr advances by 1.
- cnt_next = cnt + (create_acc ? num : 0) - retire_acc, with no saturation. The rdy rule guarantees no overflow, and retire requires cnt > 0.
- Simultaneous create and retire is legal, including in the same entry index at wrap. For example, with cnt == ENTRY_NUM-2 and a 2-wide create plus a retire, cnt becomes ENTRY_NUM-1.
- ibuf_idu_inst_vld = !ibuf_empty | bypass.
- Flush:
  - All create/retire enables are 0 in the flush cycle.
  - wr_ptr, rd_ptr and cnt are 0 next cycle.
  - Entries clear their own valid bits from ibuf_flush_en.
- Illegal num while vld is not checked; it is a simulation assertion only.
- Reset mid-operation returns all state to reset values asynchronously.

## Timing
- All enable and status outputs are combinational from registered state plus the current-cycle inputs. There are no internal handshake stalls.
- Create accepted in cycle N: entry valid and ibuf_idu_inst_vld in N+1. Retire is possible in N+1, giving a minimum 1-cycle fetch-to-decode latency (0 with bypass).
- Reset values: inst_vld 0, empty 1, full 0, create_rdy 1, cnt 0, rd_ptr 0, bypass_sel 0, all enable vectors 0.

## Configuration
- IBUF_BYPASS_EN defined:
  - bypass = create_acc & ibuf_empty & idu_ibuf_retire_rdy.
  - On bypass, ibuf_idu_bypass_sel=1 and inst_vld=1, and slot 0 is not written.
  - If num==2, slot 1 is written to entry wr_ptr with sel=1.
  - Pointers and cnt advance by num-1 for both wr_ptr and cnt; rd_ptr is unchanged when num==1 and stays at the written entry when num==2.
- IBUF_BYPASS_EN undefined: bypass is constant 0 and ibuf_idu_bypass_sel is tied 0.

## Test plan
- Reset, then 1-wide create with idu_rdy=0: create_en=8'h01, sel=0. Next cycle cnt=1, inst_vld=1, rd_ptr=0.
- From cnt=0 at wr_ptr=7, 2-wide create: create_en=8'h81, sel=8'h01, wr_ptr→1, cnt=2.
- Fill to cnt=6: create_rdy=1. At cnt=7: create_rdy=0 and a vld create is ignored. At cnt=8: full=1.
- At cnt=7, same-cycle retire plus offered create: only retire_en asserts (rdy=0), cnt→6. Next cycle, 2-wide create plus retire gives cnt 6→7.
- Flush with cnt=5 and concurrent vld and retire: all enables 0, next cycle cnt=0, ptrs=0, empty=1.
- With IBUF_BYPASS_EN, empty buffer, idu_rdy=1, 2-wide create: bypass_sel=1, create_en has only wr_ptr set with sel=1, cnt→1. Without the macro: no bypass, create_en two-hot, cnt→2.

Source files
------------

// File: rtl/aq_ifu_ibuf_ctrl.sv
// IFU ibuf pointer/occupancy control: fetch-to-IDU valid in 1 cycle, or 0 with the IBUF_BYPASS_EN head bypass.
// Backpressure: create_rdy is low when fewer than 2 entries are free; the head is held until idu_ibuf_retire_rdy.
module aq_ifu_ibuf_ctrl #(
  parameter int ENTRY_NUM = 8,
  parameter int PTR_W     = 3
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst_b,
  input  logic                 ibuf_flush_en,
  input  logic                 ifu_ibuf_create_vld,
  input  logic [1:0]           ifu_ibuf_create_num,
  output logic                 ibuf_ifu_create_rdy,
  output logic [ENTRY_NUM-1:0] ibuf_entry_create_en,
  output logic [ENTRY_NUM-1:0] ibuf_entry_create_sel,
  output logic                 ibuf_idu_inst_vld,
  input  logic                 idu_ibuf_retire_rdy,
  output logic [ENTRY_NUM-1:0] ibuf_entry_retire_en,
  output logic [PTR_W-1:0]     ibuf_rd_ptr,
  output logic [PTR_W:0]       ibuf_entry_cnt,
  output logic                 ibuf_empty,
  output logic                 ibuf_full,
  output logic                 ibuf_idu_bypass_sel
);

  localparam logic [PTR_W:0] ENTRY_CNT = (PTR_W+1)'(ENTRY_NUM);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [PTR_W:0]   cnt_nxt;
  logic [PTR_W-1:0] wr_ptr_p1;
  logic [PTR_W:0]   free_cnt;
  logic             create_acc;
  logic             retire_acc;
  logic             bypass;
  logic             num_is2;
  logic [1:0]       wr_adv;

  assign free_cnt            = ENTRY_CNT - cnt;
  assign ibuf_ifu_create_rdy = free_cnt >= (PTR_W+1)'(2);
  assign ibuf_empty          = cnt == '0;
  assign ibuf_full           = cnt == ENTRY_CNT;
  assign ibuf_entry_cnt      = cnt;
  assign ibuf_rd_ptr         = rd_ptr;

  assign num_is2    = ifu_ibuf_create_num == 2'd2;
  assign create_acc = ifu_ibuf_create_vld & ibuf_ifu_create_rdy & ~ibuf_flush_en;
  assign wr_ptr_p1  = wr_ptr + PTR_W'(1);

`ifdef IBUF_BYPASS_EN
  // Empty buffer and a ready IDU: slot 0 goes straight to decode.
  assign bypass = create_acc & ibuf_empty & idu_ibuf_retire_rdy;
`else
  assign bypass = 1'b0;
`endif

  assign ibuf_idu_bypass_sel = bypass;
  assign ibuf_idu_inst_vld   = ~ibuf_empty | bypass;
  assign retire_acc = ibuf_idu_inst_vld & idu_ibuf_retire_rdy & ~ibuf_flush_en & ~bypass;

  always_comb begin
    ibuf_entry_create_en  = '0;
    ibuf_entry_create_sel = '0;
    wr_adv                = 2'd0;
    if (create_acc) begin
      if (bypass) begin
        wr_adv = num_is2 ? 2'd1 : 2'd0;
        if (num_is2) begin
          ibuf_entry_create_en[wr_ptr]  = 1'b1;
          ibuf_entry_create_sel[wr_ptr] = 1'b1;
        end
      end else begin
        wr_adv = num_is2 ? 2'd2 : 2'd1;
        ibuf_entry_create_en[wr_ptr] = 1'b1;
        if (num_is2) begin
          ibuf_entry_create_en[wr_ptr_p1]  = 1'b1;
          ibuf_entry_create_sel[wr_ptr_p1] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ibuf_entry_retire_en = '0;
    if (retire_acc) begin
      ibuf_entry_retire_en[rd_ptr] = 1'b1;
    end
  end

  assign wr_ptr_nxt = wr_ptr + PTR_W'(wr_adv);
  assign rd_ptr_nxt = rd_ptr + PTR_W'(retire_acc);
  assign cnt_nxt    = cnt + (PTR_W+1)'(wr_adv) - (PTR_W+1)'(retire_acc);

  // Entries drop their own valid bits on flush; only the pointers live here.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (ibuf_flush_en) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      cnt    <= cnt_nxt;
    end
  end

  a_create_num_legal: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
    ifu_ibuf_create_vld |-> (ifu_ibuf_create_num == 2'd1 || ifu_ibuf_create_num == 2'd2));

endmodule
